uart_tx_fifo: RTL and testbench

- Parametrised successor to the single-byte UART transmitter used by the SoC top level.
- Adds a synchronous TX FIFO with a valid/ready write port, configurable data width, stop bits and baud divisor, plus optional parity.
- Sits between the CPU/peripheral bus (or test pattern generators) and the Tx pin.
- Lets producers burst several characters without polling busy between bytes.

---
 rtl/uart_defs.sv | 22 ++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and defaults.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
package uart_defs;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_t;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLK_DIV = 868;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; an extra pointer bit
// separates full from empty.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    // A full FIFO refuses writes even when a pop happens in the same cycle
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign data_out = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a FIFO, frame FSM to Tx.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo
    import uart_defs::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          Tx_o
);

    localparam int              CW        = $clog2(CLK_DIV);
    localparam int              BW        = $clog2(DATA_W);
    localparam logic [CW-1:0]   BAUD_LOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_W - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);

    tx_state_t          state_reg, state_next;
    logic [CW-1:0]      baud_reg, baud_next;
    logic [BW-1:0]      bit_reg, bit_next;
    logic               stop_reg, stop_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic               tx_reg, tx_next;
    logic               load_frame;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  head;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (valid_i),
        .pop      (pop),
        .data_in  (data_i),
        .data_out (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level_o)
    );

    assign ready_o = !fifo_full;
    assign busy_o  = (level_o != '0) || (state_reg != IDLE);
    assign Tx_o    = tx_reg;

`ifdef UART_TX_PARITY_EN
    logic parity_reg, parity_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD[0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            stop_reg  <= 1'b0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            stop_reg  <= stop_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        stop_next  = stop_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        load_frame = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        // Every bit-time ends when the down-counter reaches zero
        if (baud_reg != '0) begin
            baud_next = baud_reg - 1'b1;
        end

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    load_frame = 1'b1;
                end
            end
            START: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_LOAD;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_reg == '0) begin
                    baud_next = BAUD_LOAD;
                    if (bit_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_reg;
                        state_next = PARITY;
`else
                        tx_next    = 1'b1;
                        stop_next  = 1'b0;
                        state_next = STOP;
`endif
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        tx_next    = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_LOAD;
                    tx_next    = 1'b1;
                    stop_next  = 1'b0;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_reg == '0) begin
                    if (stop_reg == STOP_LAST) begin
                        if (!fifo_empty) begin
                            load_frame = 1'b1;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        stop_next = stop_reg + 1'b1;
                        baud_next = BAUD_LOAD;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase

        // Pop the head and drive the start bit; shared by IDLE and back-to-back STOP exit
        if (load_frame) begin
            pop        = 1'b1;
            shift_next = head;
            baud_next  = BAUD_LOAD;
            tx_next    = 1'b0;
            state_next = START;
`ifdef UART_TX_PARITY_EN
            parity_next = (^head) ^ PARITY_ODD[0];
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, per-line
// monitors decode Tx and compare.
module tb_uart_tx_fifo;

    localparam int TB_DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         b2b;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d8;
    logic       v8;
    logic       r8;
    logic [4:0] lvl8;
    logic       busy8;
    logic       tx8;
    logic [4:0] d5;
    logic       v5;
    logic       r5;
    logic [2:0] lvl5;
    logic       busy5;
    logic       tx5;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb8[$];
    exp_t sb5[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(
        .CLK_DIV(TB_DIV), .DATA_W(8), .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(0)
    ) dut8 (
        .clk(clk), .rst(rst), .data_i(d8), .valid_i(v8), .ready_o(r8),
        .level_o(lvl8), .busy_o(busy8), .Tx_o(tx8)
    );

    uart_tx_fifo #(
        .CLK_DIV(TB_DIV), .DATA_W(5), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut5 (
        .clk(clk), .rst(rst), .data_i(d5), .valid_i(v5), .ready_o(r5),
        .level_o(lvl5), .busy_o(busy5), .Tx_o(tx5)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic line(input int which);
        return (which != 0) ? tx5 : tx8;
    endfunction

    // Called on the negedge where the start bit was first seen low
    task automatic rx_frame(input int which, input int dw, input int sb,
                            output logic [7:0] d, output logic p, output bit ok, output bit ab);
        logic v;
        d = '0; p = 1'b0; ok = 1'b1; ab = 1'b0;
        for (int i = 1; i < TB_DIV; i++) begin
            @(negedge clk);
            if (rst !== 1'b1) begin ab = 1'b1; return; end
            if (line(which) !== 1'b0) ok = 1'b0;
        end
        for (int b = 0; b < dw; b++) begin
            for (int k = 0; k < TB_DIV; k++) begin
                @(negedge clk);
                if (rst !== 1'b1) begin ab = 1'b1; return; end
                v = line(which);
                if (k == 0) d[b] = v;
                else if (v !== d[b]) ok = 1'b0;
            end
        end
        if (PAR) begin
            for (int k = 0; k < TB_DIV; k++) begin
                @(negedge clk);
                if (rst !== 1'b1) begin ab = 1'b1; return; end
                v = line(which);
                if (k == 0) p = v;
                else if (v !== p) ok = 1'b0;
            end
        end
        for (int s = 0; s < sb * TB_DIV; s++) begin
            @(negedge clk);
            if (rst !== 1'b1) begin ab = 1'b1; return; end
            if (line(which) !== 1'b1) ok = 1'b0;
        end
    endtask

    initial begin : mon8
        exp_t e; logic [7:0] d; logic p; bit ok; bit ab; int st; int last_end;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx8 === 1'b0) begin
                st = cyc;
                rx_frame(0, 8, 1, d, p, ok, ab);
                if (!ab) begin
                    if (sb8.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_frame8 got %0h want none (cycle %0d)", d, st);
                    end else begin
                        e = sb8.pop_front();
                        $display("frame8 data=%02h start=%0d", d, st);
                        chk("frame8_data", d, e.data);
                        chk("frame8_shape", ok, 1);
                        if (e.b2b) chk("frame8_b2b", st, last_end + 1);
                        if (e.start >= 0) chk("frame8_start", st, e.start);
                        if (PAR) chk("frame8_parity", p, ^e.data);
                    end
                    last_end = cyc;
                end
            end
        end
    end

    initial begin : mon5
        exp_t e; logic [7:0] d; logic p; bit ok; bit ab; int st; int last_end;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx5 === 1'b0) begin
                st = cyc;
                rx_frame(1, 5, 2, d, p, ok, ab);
                if (!ab) begin
                    if (sb5.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_frame5 got %0h want none (cycle %0d)", d, st);
                    end else begin
                        e = sb5.pop_front();
                        $display("frame5 data=%02h start=%0d", d, st);
                        chk("frame5_data", d, e.data);
                        chk("frame5_shape", ok, 1);
                        if (e.b2b) chk("frame5_b2b", st, last_end + 1);
                        if (e.start >= 0) chk("frame5_start", st, e.start);
                        if (PAR) chk("frame5_parity", p, ^e.data);
                    end
                    last_end = cyc;
                end
            end
        end
    end

    // Entered and left on a negedge; acc is the bench's own prediction of acceptance
    task automatic push8(input logic [7:0] d, input bit acc, input bit frame, input bit b2b,
                         input bit cstart, output int e);
        chk("ready8", r8, acc);
        v8 = 1'b1; d8 = d;
        @(posedge clk); #1;
        e = cyc;
        if (acc && frame) sb8.push_back('{d, b2b, cstart ? e + 1 : -1});
        @(negedge clk);
        v8 = 1'b0; d8 = 8'hxx;
    endtask

    task automatic push5(input logic [4:0] d, input bit b2b, input bit cstart, output int e);
        chk("ready5", r5, 1);
        v5 = 1'b1; d5 = d;
        @(posedge clk); #1;
        e = cyc;
        sb5.push_back('{{3'b000, d}, b2b, cstart ? e + 1 : -1});
        @(negedge clk);
        v5 = 1'b0; d5 = 5'h00;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((sb8.size() != 0 || sb5.size() != 0 || busy8 || busy5) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", (n < limit), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        fails++;
        $display("FAIL watchdog got timeout want completion (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : stim
        int e; int e2; int t;
        rst = 1'b0; v8 = 1'b0; d8 = '0; v5 = 1'b0; d5 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx8, 1);
        chk("rst_ready", r8, 1);
        chk("rst_level", lvl8, 0);
        chk("rst_busy", busy8, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte into idle block: 40-cycle frame, busy drops after it
        push8(8'hA5, 1, 1, 0, 1, e);
        chk("single_level", lvl8, 1);
        wait_cycle(e + 40);
        chk("single_busy_last", busy8, 1);
        wait_cycle(e + 41);
        chk("single_busy_drop", busy8, 0);
        repeat (4) @(negedge clk);

        // Burst of 3 on consecutive cycles; frames back-to-back
        push8(8'h01, 1, 1, 0, 1, e);
        chk("burst_level0", lvl8, 1);
        push8(8'h02, 1, 1, 1, 0, t);
        chk("burst_level1", lvl8, 1);
        push8(8'h03, 1, 1, 1, 0, t);
        chk("burst_level2", lvl8, 2);
        wait_cycle(e + 40);
        chk("burst_level_pre", lvl8, 2);
        wait_cycle(e + 41);
        chk("burst_level_pop1", lvl8, 1);
        wait_cycle(e + 81);
        chk("burst_level_pop2", lvl8, 0);
        wait_drain(300);

        // Fill while one frame is in flight: 16 accepted, 17th refused
        push8(8'hC0, 1, 1, 0, 1, e);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            push8(8'h10 + 8'(i), (i < 16), 1, 1, 0, t);
        end
        chk("fill_level", lvl8, 16);
        chk("fill_ready", r8, 0);
        wait_drain(1000);

        // Reset mid-DATA of 0x55 with two queued bytes: nothing more is sent
        push8(8'h55, 1, 0, 0, 0, e);
        push8(8'h66, 1, 0, 0, 0, t);
        push8(8'h77, 1, 0, 0, 0, t);
        chk("abort_level_pre", lvl8, 2);
        wait_cycle(e + 10);
        #2 rst = 1'b0;
        #1;
        chk("abort_tx", tx8, 1);
        chk("abort_level", lvl8, 0);
        chk("abort_ready", r8, 1);
        chk("abort_busy", busy8, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        chk("abort_quiet_tx", tx8, 1);
        chk("abort_quiet_busy", busy8, 0);

        // DATA_W=5, STOP_BITS=2: 32-cycle frames, second one back-to-back
        push5(5'h1F, 0, 1, e2);
        push5(5'h0A, 1, 0, t);
        wait_cycle(e2 + 64);
        chk("w5_busy_last", busy5, 1);
        wait_cycle(e2 + 65);
        chk("w5_busy_drop", busy5, 0);
        wait_drain(200);

        chk("sb8_empty", sb8.size(), 0);
        chk("sb5_empty", sb5.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
